// File: rtl/redmule_mx_decode_arbiter.sv
// redmule_mx_decode_arbiter: shares one MX decoder between NUM_REQ operand streamers, one whole block per grant
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  per-requester block+exponent handshake
//   req_val_data_i             value blocks, requester r at [r*DATA_W +: DATA_W]
//   req_exp_data_i             shared exponents, requester r at [r*8 +: 8]
//   dec_val_valid_o/ready_i/data_o  value block towards the decoder
//   dec_exp_valid_o/ready_i/data_o  shared exponent towards the decoder
//   dec_fp16_valid_i/ready_o/data_i decoded element stream from the decoder
//   out_valid_o / out_ready_i  per-requester element handshake, only the owner sees valid
//   out_data_o                 decoded element, broadcast to all requesters
//   busy_o                     a block is being issued or drained
//
// Build option: define REDMULE_MX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// rr_ptr_q stays 0); left undefined, arbitration is round-robin.
module redmule_mx_decode_arbiter #(
   parameter int unsigned DATA_W  = 256,
   parameter int unsigned BITW    = 16,
   parameter int unsigned NUM_REQ = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_val_data_i,
   input  logic [NUM_REQ*8-1:0]      req_exp_data_i,
   output logic                      dec_val_valid_o,
   input  logic                      dec_val_ready_i,
   output logic [DATA_W-1:0]         dec_val_data_o,
   output logic                      dec_exp_valid_o,
   input  logic                      dec_exp_ready_i,
   output logic [7:0]                dec_exp_data_o,
   input  logic                      dec_fp16_valid_i,
   output logic                      dec_fp16_ready_o,
   input  logic [BITW-1:0]           dec_fp16_data_i,
   output logic [NUM_REQ-1:0]        out_valid_o,
   input  logic [NUM_REQ-1:0]        out_ready_i,
   output logic [BITW-1:0]           out_data_o,
   output logic                      busy_o
);
   localparam int unsigned NUM_ELEMS = DATA_W / 8;
   localparam int unsigned OW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(NUM_ELEMS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   state_e        state_q;
   logic [OW-1:0] owner_q;
   logic [OW-1:0] rr_ptr_q;
   logic [OW-1:0] winner;
   logic [CW-1:0] elem_cnt_q;
   logic          in_issue;
   logic          in_drain;
   logic          issue_hs;
   logic          elem_hs;

   // Scanning backwards lets the closest valid requester at or after rr_ptr_q overwrite the others.
   always_comb begin
      winner = rr_ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid_i[OW'((int'(rr_ptr_q) + k) % int'(NUM_REQ))])
            winner = OW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      end
   end

   assign in_issue = state_q == ISSUE;
   assign in_drain = state_q == DRAIN;
   assign issue_hs = in_issue & req_valid_i[owner_q] & dec_val_ready_i & dec_exp_ready_i;
   assign elem_hs  = in_drain & dec_fp16_valid_i & out_ready_i[owner_q];
   assign busy_o   = state_q != IDLE;

   always_comb begin
      req_ready_o          = '0;
      out_valid_o          = '0;
      req_ready_o[owner_q] = in_issue & dec_val_ready_i & dec_exp_ready_i;
      out_valid_o[owner_q] = in_drain & dec_fp16_valid_i;
   end

   assign dec_val_valid_o  = in_issue & req_valid_i[owner_q];
   assign dec_exp_valid_o  = dec_val_valid_o;
   assign dec_val_data_o   = in_issue ? req_val_data_i[owner_q*DATA_W +: DATA_W] : '0;
   assign dec_exp_data_o   = in_issue ? req_exp_data_i[owner_q*8 +: 8] : '0;
   assign dec_fp16_ready_o = in_drain & out_ready_i[owner_q];
   assign out_data_o       = in_drain ? dec_fp16_data_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         elem_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid_i) begin
                  owner_q    <= winner;
                  elem_cnt_q <= '0;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_hs) state_q <= DRAIN;
            end
            DRAIN: begin
               if (elem_hs) begin
                  if (elem_cnt_q == CW'(NUM_ELEMS - 1)) begin
                     elem_cnt_q <= '0;
                     state_q    <= IDLE;
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
                     rr_ptr_q   <= (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
                  end else begin
                     elem_cnt_q <= elem_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_redmule_mx_decode_arbiter.sv
// tb_redmule_mx_decode_arbiter: randomized and directed bench for the shared MX decoder arbiter
module tb_redmule_mx_decode_arbiter;
   localparam int DW = 256;
   localparam int BW = 16;
   localparam int NR = 2;
   localparam int NE = DW / 8;
   localparam int W  = 256;

   typedef logic [DW+7:0] blk_t;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NR-1:0]     req_valid_i;
   logic [NR-1:0]     req_ready_o;
   logic [NR*DW-1:0]  req_val_data_i;
   logic [NR*8-1:0]   req_exp_data_i;
   logic              dec_val_valid_o;
   logic              dec_val_ready_i;
   logic [DW-1:0]     dec_val_data_o;
   logic              dec_exp_valid_o;
   logic              dec_exp_ready_i;
   logic [7:0]        dec_exp_data_o;
   logic              dec_fp16_valid_i;
   logic              dec_fp16_ready_o;
   logic [BW-1:0]     dec_fp16_data_i;
   logic [NR-1:0]     out_valid_o;
   logic [NR-1:0]     out_ready_i;
   logic [BW-1:0]     out_data_o;
   logic              busy_o;

   redmule_mx_decode_arbiter #(.DATA_W(DW), .BITW(BW), .NUM_REQ(NR)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_val_data_i(req_val_data_i), .req_exp_data_i(req_exp_data_i),
      .dec_val_valid_o(dec_val_valid_o), .dec_val_ready_i(dec_val_ready_i), .dec_val_data_o(dec_val_data_o),
      .dec_exp_valid_o(dec_exp_valid_o), .dec_exp_ready_i(dec_exp_ready_i), .dec_exp_data_o(dec_exp_data_o),
      .dec_fp16_valid_i(dec_fp16_valid_i), .dec_fp16_ready_o(dec_fp16_ready_o), .dec_fp16_data_i(dec_fp16_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   blk_t        blk_q[NR][$];
   logic [15:0] exp_q[NR][$];
   int          order_q[$];
   bit          m_busy, m_issued;
   int          m_owner, m_left, m_next;
   bit          dbusy;
   logic [DW-1:0] dblk;
   logic [7:0]  dexp;
   int          didx;
   bit          want[NR], raised[NR], lit_en[NR];
   logic [15:0] lit_val[NR];
   int          rcv[NR], hs_cnt[NR];
   int          p_dr, p_or[NR], p_fv, p_spur;
   bit          rnd_want;
   int          busy_cnt, mode;
   logic [DW-1:0] held;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   // E4M3 element scaled by the E8M0 exponent; values outside the FP16 normal range fall back to a tag
   function automatic logic [15:0] mx_dec(input logic [7:0] b, input logic [7:0] e);
      int ue;
      ue = int'(b[6:3]) - 7 + int'(e) - 127 + 15;
      if (b[6:3] != 4'h0 && b[6:3] != 4'hF && ue >= 1 && ue <= 30) return {b[7], 5'(ue), b[2:0], 7'b0};
      return {e, b};
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   function automatic bit all_done();
      return !m_busy && !dbusy && blk_q[0].size() == 0 && blk_q[1].size() == 0;
   endfunction

   task automatic full_speed();
      p_dr = 100;
      p_fv = 100;
      p_spur = 0;
      rnd_want = 0;
      for (int r = 0; r < NR; r++) p_or[r] = 100;
   endtask

   task automatic push_blk(input int r, input logic [7:0] ex, input bit fixed38);
      logic [DW-1:0] d;
      for (int i = 0; i < NE; i++) d[i*8 +: 8] = fixed38 ? 8'h38 : 8'($urandom);
      blk_q[r].push_back({d, ex});
   endtask

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         if (rnd_want) want[r] = pct(60);
         raised[r] = blk_q[r].size() > 0 && (raised[r] || want[r]);
         req_valid_i[r] = raised[r];
         req_val_data_i[r*DW +: DW] = blk_q[r].size() > 0 ? blk_q[r][0][DW+7:8] : '0;
         req_exp_data_i[r*8 +: 8] = blk_q[r].size() > 0 ? blk_q[r][0][7:0] : '0;
         out_ready_i[r] = pct(p_or[r]);
      end
      dec_val_ready_i = !dbusy && pct(p_dr);
      dec_exp_ready_i = !dbusy && pct(p_dr);
      dec_fp16_valid_i = dbusy ? pct(p_fv) : pct(p_spur);
      dec_fp16_data_i = dbusy ? mx_dec(dblk[didx*8 +: 8], dexp) : 16'($urandom);
   endtask

   task automatic check_cycle();
      bit iss, drn;
      logic [NR-1:0] e_rr, e_ov;
      logic [DW-1:0] e_vd;
      logic [7:0] e_ed;
      logic [15:0] e;
      bit found;
      iss = m_busy && !m_issued;
      drn = m_busy && m_issued;
      e_vd = '0;
      e_ed = '0;
      if (iss && blk_q[m_owner].size() > 0) begin
         e_vd = blk_q[m_owner][0][DW+7:8];
         e_ed = blk_q[m_owner][0][7:0];
      end
      e_rr = '0;
      e_ov = '0;
      if (iss) e_rr[m_owner] = dec_val_ready_i & dec_exp_ready_i;
      if (drn) e_ov[m_owner] = dec_fp16_valid_i;
      chk("busy", W'(busy_o), W'(m_busy));
      chk("dec_val_valid", W'(dec_val_valid_o), W'(iss && req_valid_i[m_owner]));
      chk("dec_exp_valid", W'(dec_exp_valid_o), W'(iss && req_valid_i[m_owner]));
      chk("dec_val_data", W'(dec_val_data_o), W'(e_vd));
      chk("dec_exp_data", W'(dec_exp_data_o), W'(e_ed));
      chk("req_ready", W'(req_ready_o), W'(e_rr));
      chk("out_valid", W'(out_valid_o), W'(e_ov));
      chk("out_data", W'(out_data_o), W'(drn ? dec_fp16_data_i : 16'h0));
      chk("fp16_ready", W'(dec_fp16_ready_o), W'(drn && out_ready_i[m_owner]));
      if (mode == 1) chk("bp_fp16_ready", W'(dec_fp16_ready_o), '0);
      if (mode == 2) begin
         chk("dnr_req_ready", W'(req_ready_o), '0);
         chk("dnr_data_stable", W'(dec_val_data_o), W'(held));
      end
      if (mode == 3) chk("dnr_req_ready_go", W'(req_ready_o), W'(2'b01));
      busy_cnt += int'(busy_o);
      for (int r = 0; r < NR; r++) begin
         if (out_valid_o[r] && out_ready_i[r]) begin
            rcv[r]++;
            if (exp_q[r].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_elem req %0d actual %0h required none", r, out_data_o);
            end else begin
               e = exp_q[r].pop_front();
               chk("elem", W'(out_data_o), W'(e));
               if (lit_en[r]) chk("elem_lit", W'(out_data_o), W'(lit_val[r]));
            end
         end
      end
      if (!m_busy) begin
         if (|req_valid_i) begin
            found = 0;
            for (int k = 0; k < NR; k++) begin
               if (!found && req_valid_i[(m_next + k) % NR]) begin
                  m_owner = (m_next + k) % NR;
                  found = 1;
               end
            end
            m_busy = 1;
            m_issued = 0;
         end
      end else if (!m_issued) begin
         if (req_valid_i[m_owner] && dec_val_ready_i && dec_exp_ready_i) begin
            m_issued = 1;
            m_left = NE;
            for (int i = 0; i < NE; i++)
               exp_q[m_owner].push_back(mx_dec(blk_q[m_owner][0][8 + i*8 +: 8], blk_q[m_owner][0][7:0]));
         end
      end else if (dec_fp16_valid_i && out_ready_i[m_owner]) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0;
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
            m_next = (m_owner + 1) % NR;
`endif
         end
      end
      for (int r = 0; r < NR; r++) begin
         if (req_valid_i[r] && req_ready_o[r] && blk_q[r].size() > 0) begin
            order_q.push_back(r);
            hs_cnt[r]++;
            blk_q[r].delete(0);
            raised[r] = 0;
         end
      end
      if (!dbusy && dec_val_valid_o && dec_exp_valid_o && dec_val_ready_i && dec_exp_ready_i) begin
         dbusy = 1;
         dblk = dec_val_data_o;
         dexp = dec_exp_data_o;
         didx = 0;
      end else if (dbusy && dec_fp16_valid_i && dec_fp16_ready_o) begin
         didx++;
         if (didx == NE) dbusy = 0;
      end
   endtask

   task automatic step();
      drive();
      @(negedge clk_i);
      check_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_idle(input string tag, input int max);
      int n = 0;
      while (!all_done() && n < max) begin
         step();
         n++;
      end
      if (!all_done()) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual %0d cycles required done", tag, max);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, W'(busy_o), '0);
      chk({tag, "_req_ready"}, W'(req_ready_o), '0);
      chk({tag, "_dec_valid"}, W'({dec_val_valid_o, dec_exp_valid_o}), '0);
      chk({tag, "_dec_data"}, W'(dec_val_data_o), '0);
      chk({tag, "_exp_data"}, W'(dec_exp_data_o), '0);
      chk({tag, "_out_valid"}, W'(out_valid_o), '0);
      chk({tag, "_out_data"}, W'(out_data_o), '0);
      chk({tag, "_fp16_ready"}, W'(dec_fp16_ready_o), '0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      req_valid_i = '0;
      req_val_data_i = '0;
      req_exp_data_i = '0;
      dec_val_ready_i = 1'b0;
      dec_exp_ready_i = 1'b0;
      dec_fp16_valid_i = 1'b0;
      dec_fp16_data_i = '0;
      out_ready_i = '0;
      for (int r = 0; r < NR; r++) begin
         blk_q[r].delete();
         exp_q[r].delete();
         raised[r] = 0;
         want[r] = 0;
         lit_en[r] = 0;
      end
      dbusy = 0;
      m_busy = 0;
      m_issued = 0;
      m_owner = 0;
      m_next = 0;
      m_left = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic chk_order(input string tag, input int o0, input int o1, input int o2, input int o3);
      int eo[4];
      eo = '{o0, o1, o2, o3};
      chk({tag, "_count"}, W'(order_q.size()), W'(4));
      for (int i = 0; i < 4; i++) chk(tag, W'(i < order_q.size() ? order_q[i] : -1), W'(eo[i]));
   endtask

   initial begin
      int base;
      int n;
      mode = 0;
      full_speed();
      for (int r = 0; r < NR; r++) begin
         rcv[r] = 0;
         hs_cnt[r] = 0;
      end
      rst_ni = 1'b0;
      do_reset();
      rst_ni = 1'b0;
      #1;
      check_zero("reset");
      do_reset();

      // single requester, 1.0 * 2^0
      full_speed();
      push_blk(0, 8'h7F, 1);
      lit_en[0] = 1;
      lit_val[0] = 16'h3C00;
      want[0] = 1;
      busy_cnt = 0;
      run_idle("single", 200);
      chk("single_req_ready_pulses", W'(hs_cnt[0]), W'(1));
      chk("single_elems", W'(rcv[0]), W'(NE));
      chk("single_busy_cycles", W'(busy_cnt), W'(NE + 1));
      lit_en[0] = 0;

      // both requesting continuously
      do_reset();
      full_speed();
      for (int b = 0; b < 2; b++) begin
         push_blk(0, 8'h80, 1);
         push_blk(1, 8'h7E, 1);
      end
      lit_en[0] = 1;
      lit_val[0] = 16'h4000;
      lit_en[1] = 1;
      lit_val[1] = 16'h3800;
      want[0] = 1;
      want[1] = 1;
      order_q.delete();
      run_idle("both", 400);
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
      chk_order("both_order", 0, 0, 1, 1);
`else
      chk_order("both_order", 0, 1, 0, 1);
`endif
      lit_en[0] = 0;
      lit_en[1] = 0;

      // output backpressure after element 10
      full_speed();
      push_blk(0, 8'($urandom), 0);
      want[0] = 1;
      base = rcv[0];
      n = 0;
      while (rcv[0] - base < 10 && n < 200) begin
         step();
         n++;
      end
      chk("bp_reach", W'(rcv[0] - base), W'(10));
      p_or[0] = 0;
      mode = 1;
      repeat (5) step();
      mode = 0;
      chk("bp_hold", W'(rcv[0] - base), W'(10));
      p_or[0] = 100;
      run_idle("bp", 200);
      chk("bp_total", W'(rcv[0] - base), W'(NE));

      // decoder not ready for three ISSUE cycles
      full_speed();
      p_dr = 0;
      push_blk(0, 8'($urandom), 0);
      want[0] = 1;
      n = 0;
      while (!(m_busy && !m_issued) && n < 50) begin
         step();
         n++;
      end
      held = blk_q[0][0][DW+7:8];
      mode = 2;
      repeat (3) step();
      mode = 3;
      p_dr = 100;
      step();
      mode = 0;
      run_idle("dnr", 200);

      // reset in the middle of a drain
      full_speed();
      push_blk(0, 8'($urandom), 0);
      want[0] = 1;
      base = rcv[0];
      n = 0;
      while (rcv[0] - base < 17 && n < 200) begin
         step();
         n++;
      end
      chk("rst_reach", W'(rcv[0] - base), W'(17));
      rst_ni = 1'b0;
      #1;
      check_zero("rst_mid");
      do_reset();
      full_speed();
      push_blk(1, 8'($urandom), 0);
      want[1] = 1;
      base = rcv[1];
      run_idle("after_rst", 200);
      chk("after_rst_elems", W'(rcv[1] - base), W'(NE));

      // randomized traffic with stalls and spurious decoder valids
      p_dr = 60;
      p_or[0] = 70;
      p_or[1] = 70;
      p_fv = 70;
      p_spur = 30;
      rnd_want = 1;
      for (int b = 0; b < 15; b++) begin
         push_blk(0, 8'($urandom), 0);
         push_blk(1, 8'($urandom), 0);
      end
      run_idle("random", 20000);
      full_speed();

      // priority scheme with an uneven backlog
      do_reset();
      full_speed();
      for (int b = 0; b < 3; b++) push_blk(0, 8'($urandom), 0);
      push_blk(1, 8'($urandom), 0);
      want[0] = 1;
      want[1] = 1;
      order_q.delete();
      run_idle("prio", 600);
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
      chk_order("prio_order", 0, 0, 0, 1);
`else
      chk_order("prio_order", 0, 1, 0, 0);
`endif

      for (int r = 0; r < NR; r++) chk("leftover_elems", W'(exp_q[r].size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/redmule_mx_decode_arbiter.md
Name: redmule_mx_decode_arbiter

Overview:
- Shares one MX decoder instance (FP8 E4M3 block + E8M0 shared exponent in, FP16 element stream out) between NUM_REQ requesters, e.g. the X and W operand streamers.
- Grants a single requester per block and forwards its value block and exponent to the decoder.
- Routes all NUM_ELEMS decoded FP16 elements back to that requester, then re-arbitrates.
- Sits between the streamers and the decoder.

Parameters:
- DATA_W, 256, width of one MX value block.
- BITW, 16, decoded element width.
- NUM_REQ, 2, number of requesters (>=2).
- NUM_ELEMS, DATA_W/8, decoded elements per block (derived localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  NUM_REQ  per-requester block+exponent valid
- req_ready_o  out  NUM_REQ  per-requester block+exponent accepted
- req_val_data_i  in  NUM_REQ*DATA_W  value blocks; requester r at slice [r*DATA_W +: DATA_W]
- req_exp_data_i  in  NUM_REQ*8  shared exponents; requester r at slice [r*8 +: 8]
- dec_val_valid_o  out  1  to decoder mx_val_valid
- dec_val_ready_i  in  1  from decoder mx_val_ready
- dec_val_data_o  out  DATA_W  to decoder mx_val_data
- dec_exp_valid_o  out  1  to decoder mx_exp_valid
- dec_exp_ready_i  in  1  from decoder mx_exp_ready
- dec_exp_data_o  out  8  to decoder mx_exp_data
- dec_fp16_valid_i  in  1  from decoder fp16_valid
- dec_fp16_ready_o  out  1  to decoder fp16_ready
- dec_fp16_data_i  in  BITW  from decoder fp16_data
- out_valid_o  out  NUM_REQ  one-hot; decoded element valid for owner only
- out_ready_i  in  NUM_REQ  per-requester element ready
- out_data_o  out  BITW  decoded element, broadcast to all requesters
- busy_o  out  1  high in ISSUE or DRAIN

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN. Registers: state, owner_q (clog2(NUM_REQ) bits), rr_ptr_q, elem_cnt_q (clog2(NUM_ELEMS) bits).
- Reset: state=IDLE, owner_q=0, rr_ptr_q=0, elem_cnt_q=0. All valid/ready outputs 0; data outputs 0; busy_o=0.
- IDLE:
  - No ready asserted.
  - If any req_valid_i is set, pick the winner round-robin: the first requester at or after rr_ptr_q, wrapping.
  - owner_q<=winner, elem_cnt_q<=0, state->ISSUE.
  - Arbitration takes one cycle, so the earliest decoder handshake is the cycle after valid is seen.
- ISSUE:
  - dec_val_valid_o = dec_exp_valid_o = req_valid_i[owner_q].
  - Data muxed from the owner's slices.
  - req_ready_o[owner_q] = dec_val_ready_i & dec_exp_ready_i; 0 for all others.
  - On owner valid & both decoder readies: handshake, state->DRAIN.
  - Requesters must hold valid and data stable until ready.
- DRAIN:
  - out_valid_o[owner_q]=dec_fp16_valid_i; others 0.
  - out_data_o=dec_fp16_data_i; dec_fp16_ready_o=out_ready_i[owner_q].
  - Each element handshake increments elem_cnt_q.
  - On the handshake with elem_cnt_q==NUM_ELEMS-1: elem_cnt_q<=0, rr_ptr_q<=(owner_q+1) mod NUM_REQ, state->IDLE.
- Outside DRAIN: out_valid_o=0, dec_fp16_ready_o=0, out_data_o=0.
- Outside ISSUE: dec_*_valid_o=0, dec_*_data_o=0.
- Non-owner requests are held off until the owner's full block has drained; no preemption.
- Owner valid dropping in ISSUE is a protocol violation; the FSM simply waits.
- Unexpected dec_fp16_valid_i in IDLE/ISSUE is not acknowledged.
- Reset mid-block returns all registers to reset values immediately. Decoder and requesters are reset by the same rst_ni.
- Throughput: per block, 1 (arbitrate) + 1 (issue) + NUM_ELEMS cycles at full readiness, assuming the decoder's 1-cycle latch.

Optional Feature:
- Macro: REDMULE_MX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr_q is not updated and stays 0.
- Undefined: round-robin as above.

Test Plan:
- Single requester: req0 valid, block of 32×0x38, exp 0x7F -> 32 elements of 0x3C00 on out_data_o, out_valid_o=2'b01, then IDLE; req_ready_o[0] pulses once.
- Both requesting continuously with exp 0x80 (req0) and 0x7E (req1), all 0x38 -> blocks served in order 0,1,0,1. req0 elements 0x4000, req1 elements 0x3800.
- Backpressure: out_ready_i[0] low for 5 cycles mid-DRAIN (after element 10) -> dec_fp16_ready_o low for those cycles, elem_cnt_q holds at 10, no element lost or duplicated.
- Decoder not ready: dec_val_ready_i low 3 cycles in ISSUE -> req_ready_o stays 0, data held stable, handshake on the 4th cycle.
- Reset asserted in DRAIN at elem_cnt_q=17 -> all outputs 0 immediately. After release, a new req1 block is served from element 0.
- With REDMULE_MX_ARB_FIXED_PRIO_EN and both valid -> req0 served on every arbitration; req1 starves until req0 drops valid.
